// File: rtl/sw_alloc_rr.sv
// Switch allocator: one round-robin, packet-atomic arbiter per router output port.
// Optional macro ALLOC_TIMEOUT_EN adds per-output stall counters that force-release stuck locks.
module sw_alloc_rr #(
    parameter int Num_input = 5,
    parameter int Select    = 3,
    parameter int Timeout   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [Num_input-1:0]          req,
    input  logic [Num_input*Select-1:0]   dest,
    input  logic [Num_input-1:0]          valid,
    input  logic [Num_input-1:0]          tail,
    output logic [Num_input-1:0]          grant,
    output logic [Num_input*Select-1:0]   sel,
    output logic [Num_input-1:0]          timeout
);

    // The all-ones select code marks an idle output, so it must not be a real port index.
    if (Num_input > (2**Select) - 1) begin : g_bad_select
        $error("Select too narrow for Num_input");
    end
    if (Timeout < 1) begin : g_bad_timeout
        $error("Timeout must be at least 1");
    end

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t              state_q [Num_input];
    state_t              state_d [Num_input];
    logic [Select-1:0]   owner_q [Num_input];
    logic [Select-1:0]   owner_d [Num_input];
    logic [Select-1:0]   ptr_q   [Num_input];
    logic [Select-1:0]   ptr_d   [Num_input];
    logic [Num_input-1:0]        grant_d;
    logic [Num_input*Select-1:0] sel_d;
    logic                found;
    logic [Select-1:0]   pick;
    int                  idx;

`ifdef ALLOC_TIMEOUT_EN
    localparam int CntW = $clog2(Timeout + 1);
    logic [CntW-1:0]      cnt_q [Num_input];
    logic [CntW-1:0]      cnt_d [Num_input];
    logic [Num_input-1:0] timeout_d;
    logic [Num_input-1:0] timeout_q;
`endif

    // grant and sel are rebuilt from next-state so the registered outputs always match the FSMs.
    always_comb begin
        grant_d = '0;
        sel_d   = '1;
        found   = 1'b0;
        pick    = '0;
        idx     = 0;
`ifdef ALLOC_TIMEOUT_EN
        timeout_d = '0;
`endif
        for (int o = 0; o < Num_input; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            ptr_d[o]   = ptr_q[o];
            found      = 1'b0;
            pick       = '0;
`ifdef ALLOC_TIMEOUT_EN
            cnt_d[o]   = cnt_q[o];
`endif
            case (state_q[o])
                IDLE: begin
                    for (int k = 0; k < Num_input; k++) begin
                        idx = int'(ptr_q[o]) + k;
                        if (idx >= Num_input) idx = idx - Num_input;
                        if (!found && req[idx] && !grant[idx] &&
                            dest[idx*Select +: Select] == Select'(o)) begin
                            found = 1'b1;
                            pick  = Select'(idx);
                        end
                    end
                    if (found) begin
                        state_d[o] = LOCKED;
                        owner_d[o] = pick;
                        ptr_d[o]   = (int'(pick) == Num_input - 1) ? '0 : pick + 1'b1;
                    end
                end
                LOCKED: begin
                    if (valid[owner_q[o]] && tail[owner_q[o]]) begin
                        state_d[o] = IDLE;
                    end
`ifdef ALLOC_TIMEOUT_EN
                    else if (valid[owner_q[o]]) begin
                        cnt_d[o] = '0;
                    end else if (cnt_q[o] == CntW'(Timeout - 1)) begin
                        state_d[o]   = IDLE;
                        timeout_d[o] = 1'b1;
                    end else begin
                        cnt_d[o] = cnt_q[o] + 1'b1;
                    end
                    if (state_d[o] == IDLE) cnt_d[o] = '0;
`endif
                end
                default: state_d[o] = IDLE;
            endcase
            if (state_d[o] == LOCKED) begin
                grant_d[owner_d[o]]         = 1'b1;
                sel_d[o*Select +: Select]   = owner_d[o];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < Num_input; o++) begin
                state_q[o] <= IDLE;
                owner_q[o] <= '0;
                ptr_q[o]   <= '0;
            end
            grant <= '0;
            sel   <= '1;
        end else begin
            for (int o = 0; o < Num_input; o++) begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                ptr_q[o]   <= ptr_d[o];
            end
            grant <= grant_d;
            sel   <= sel_d;
        end
    end

`ifdef ALLOC_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < Num_input; o++) cnt_q[o] <= '0;
            timeout_q <= '0;
        end else begin
            for (int o = 0; o < Num_input; o++) cnt_q[o] <= cnt_d[o];
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = '0;
`endif

endmodule
